uart_rx_frame: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_tick_gen.sv | 56 +++++
 rtl/uart_rx_frame.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame receiver.
// The 2-of-3 sample vote helper is only used when RX_MAJORITY_VOTE_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int FRAME_W   = 56;
   localparam int CHAR_W    = 8;
   localparam int NUM_CHARS = 7;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: latches the baud select while the receiver is quiet
// and divides the system clock down to one tick per oversample period.
module uart_rx_tick_gen #(
   parameter int DIV0 = 326,
   parameter int DIV1 = 163,
   parameter int DIV2 = 81,
   parameter int DIV3 = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] clk_rate,
   input  logic       latch_en,
   output logic       tick
);

   localparam int CW = 16;

   function automatic int div_of(input int idx);
      case (idx)
         0:       return DIV0;
         1:       return DIV1;
         2:       return DIV2;
         default: return DIV3;
      endcase
   endfunction

   logic [CW-1:0] div_tab [4];
   logic [CW-1:0] div_reg;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] div_eff;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_div
         assign div_tab[gi] = CW'(div_of(gi) - 1);
      end
   endgenerate

   // Reload from the live selection while latching so a new rate takes effect
   // on the very next period instead of after one stale period.
   assign div_eff = latch_en ? div_tab[clk_rate] : div_reg;
   assign tick    = (cnt_reg == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg <= CW'(DIV0 - 1);
         cnt_reg <= '0;
      end else begin
         if (latch_en) begin
            div_reg <= div_tab[clk_rate];
         end
         cnt_reg <= tick ? div_eff : cnt_reg - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver assembling seven characters into one 56-bit frame with parity,
// stop-bit and inter-character timeout checks. Define RX_MAJORITY_VOTE_EN for 3-sample voting.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int OVS          = 16,
   parameter int DIV0         = 326,
   parameter int DIV1         = 163,
   parameter int DIV2         = 81,
   parameter int DIV3         = 27,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               SData_Rx,
   input  logic [1:0]         clk_rate,
   input  logic               ParEN,
   input  logic               ParType,
   output logic [FRAME_W-1:0] Frame,
   output logic               FrameVLD,
   output logic               Par_Err,
   output logic               Stop_Err,
   output logic               Tout_Err,
   output logic               BUSY
);

   localparam int PW = $clog2(OVS);
   localparam int TW = $clog2(TIMEOUT_BITS * OVS + 1);
   localparam int BW = $clog2(NUM_CHARS);
   localparam logic [PW-1:0] PH_LAST  = PW'(OVS - 1);
   localparam logic [PW-1:0] PH_MID   = PW'(OVS / 2);
   localparam logic [PW-1:0] PH_DEC   = PW'(OVS / 2 + 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_BITS * OVS - 1);
   localparam logic [BW-1:0] LAST_CHAR = BW'(NUM_CHARS - 1);

   logic sync1_reg, sync2_reg, line;
   logic tick, decide, bit_val, par_exp, latch_en, store_en;

   rx_state_t            state_reg, state_next;
   logic [PW-1:0]        phase_reg, phase_next;
   logic [2:0]           bit_cnt_reg, bit_cnt_next;
   logic [CHAR_W-1:0]    data_sr_reg, data_sr_next;
   logic [BW-1:0]        byte_cnt_reg, byte_cnt_next;
   logic                 par_en_reg, par_en_next;
   logic                 par_type_reg, par_type_next;
   logic                 par_bad_reg, par_bad_next;
   logic                 brk_reg, brk_next;
   logic                 samp1_reg, samp1_next;
   logic [TW-1:0]        tout_cnt_reg, tout_cnt_next;
   logic [FRAME_W-1:0]   frame_reg, frame_next;
   logic                 frame_vld_reg, frame_vld_next;
   logic                 par_err_reg, par_err_next;
   logic                 stop_err_reg, stop_err_next;
   logic                 tout_err_reg, tout_err_next;
   logic                 busy_reg, busy_next;
   logic [(NUM_CHARS-1)*CHAR_W-1:0] lanes_flat;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= SData_Rx;
         sync2_reg <= sync1_reg;
      end
   end
   assign line = sync2_reg;

   assign latch_en = (state_reg == IDLE) && (byte_cnt_reg == '0) && line;

   uart_rx_tick_gen #(
      .DIV0 (DIV0),
      .DIV1 (DIV1),
      .DIV2 (DIV2),
      .DIV3 (DIV3)
   ) u_tick_gen (
      .clk      (CLK),
      .rst_n    (RST),
      .clk_rate (clk_rate),
      .latch_en (latch_en),
      .tick     (tick)
   );

   // Bits are decided one tick past mid-bit in both builds, so the vote window
   // (mid-1, mid, mid+1) is complete and pulse timing does not depend on the build.
   assign decide = tick && (phase_reg == PH_DEC);

`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [PW-1:0] PH_EARLY = PW'(OVS / 2 - 1);
   logic samp0_reg, samp0_next;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) samp0_reg <= 1'b1;
      else      samp0_reg <= samp0_next;
   end
   always_comb begin
      samp0_next = samp0_reg;
      if (tick && (phase_reg == PH_EARLY)) samp0_next = line;
   end
   assign bit_val = maj3(samp0_reg, samp1_reg, line);
`else
   assign bit_val = samp1_reg;
`endif

   assign par_exp = (^data_sr_reg) ^ (par_type_reg == PAR_ODD);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHARS - 1; gi++) begin : g_lane
         logic [CHAR_W-1:0] lane_reg;
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST)                                        lane_reg <= '0;
            else if (store_en && (byte_cnt_reg == BW'(gi))) lane_reg <= data_sr_reg;
         end
         assign lanes_flat[gi*CHAR_W +: CHAR_W] = lane_reg;
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg     <= IDLE;
         phase_reg     <= '0;
         bit_cnt_reg   <= '0;
         data_sr_reg   <= '0;
         byte_cnt_reg  <= '0;
         par_en_reg    <= 1'b0;
         par_type_reg  <= PAR_EVEN;
         par_bad_reg   <= 1'b0;
         brk_reg       <= 1'b0;
         samp1_reg     <= 1'b1;
         tout_cnt_reg  <= '0;
         frame_reg     <= '0;
         frame_vld_reg <= 1'b0;
         par_err_reg   <= 1'b0;
         stop_err_reg  <= 1'b0;
         tout_err_reg  <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         phase_reg     <= phase_next;
         bit_cnt_reg   <= bit_cnt_next;
         data_sr_reg   <= data_sr_next;
         byte_cnt_reg  <= byte_cnt_next;
         par_en_reg    <= par_en_next;
         par_type_reg  <= par_type_next;
         par_bad_reg   <= par_bad_next;
         brk_reg       <= brk_next;
         samp1_reg     <= samp1_next;
         tout_cnt_reg  <= tout_cnt_next;
         frame_reg     <= frame_next;
         frame_vld_reg <= frame_vld_next;
         par_err_reg   <= par_err_next;
         stop_err_reg  <= stop_err_next;
         tout_err_reg  <= tout_err_next;
         busy_reg      <= busy_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      phase_next     = phase_reg;
      bit_cnt_next   = bit_cnt_reg;
      data_sr_next   = data_sr_reg;
      byte_cnt_next  = byte_cnt_reg;
      par_en_next    = par_en_reg;
      par_type_next  = par_type_reg;
      par_bad_next   = par_bad_reg;
      brk_next       = brk_reg;
      samp1_next     = samp1_reg;
      tout_cnt_next  = tout_cnt_reg;
      frame_next     = frame_reg;
      frame_vld_next = 1'b0;
      par_err_next   = 1'b0;
      stop_err_next  = 1'b0;
      tout_err_next  = 1'b0;
      store_en       = 1'b0;

      if (tick) begin
         phase_next = (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
         if (phase_reg == PH_MID) samp1_next = line;
      end

      case (state_reg)
         IDLE: begin
            if (tick) begin
               if (!line) begin
                  state_next    = START;
                  phase_next    = '0;
                  tout_cnt_next = '0;
               end else if (byte_cnt_reg == '0) begin
                  tout_cnt_next = '0;
               end else if (tout_cnt_reg == TOUT_LAST) begin
                  tout_err_next = 1'b1;
                  byte_cnt_next = '0;
                  tout_cnt_next = '0;
               end else begin
                  tout_cnt_next = tout_cnt_reg + 1'b1;
               end
            end
         end
         START: begin
            if (decide) begin
               if (bit_val) begin
                  state_next = IDLE;
               end else begin
                  state_next    = DATA;
                  bit_cnt_next  = '0;
                  par_en_next   = ParEN;
                  par_type_next = ParType;
                  par_bad_next  = 1'b0;
               end
            end
         end
         DATA: begin
            if (decide) begin
               data_sr_next = {bit_val, data_sr_reg[CHAR_W-1:1]};
               if (bit_cnt_reg == 3'(CHAR_W - 1)) state_next = par_en_reg ? PARITY : STOP;
               else                               bit_cnt_next = bit_cnt_reg + 1'b1;
            end
         end
         PARITY: begin
            if (decide) begin
               if (bit_val != par_exp) par_bad_next = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            // A low stop bit may be a line break; hold here until the line recovers.
            if (brk_reg) begin
               if (tick && line) begin
                  brk_next   = 1'b0;
                  state_next = IDLE;
               end
            end else if (decide) begin
               if (!bit_val) begin
                  stop_err_next = 1'b1;
                  byte_cnt_next = '0;
                  brk_next      = 1'b1;
               end else if (par_bad_reg) begin
                  par_err_next  = 1'b1;
                  byte_cnt_next = '0;
                  state_next    = IDLE;
               end else begin
                  state_next = IDLE;
                  if (byte_cnt_reg == LAST_CHAR) begin
                     frame_next     = {data_sr_reg, lanes_flat};
                     frame_vld_next = 1'b1;
                     byte_cnt_next  = '0;
                  end else begin
                     store_en      = 1'b1;
                     byte_cnt_next = byte_cnt_reg + 1'b1;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE) || (byte_cnt_next != '0);
   end

   assign Frame    = frame_reg;
   assign FrameVLD = frame_vld_reg;
   assign Par_Err  = par_err_reg;
   assign Stop_Err = stop_err_reg;
   assign Tout_Err = tout_err_reg;
   assign BUSY     = busy_reg;

endmodule
